ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
Execute-stage ALU that sits directly downstream of the ALU-control decoder. It takes the 4-bit ALU control code, two operands and the destination register tag, and computes the result. The result, a zero flag and the tag go into an output register that feeds EX/MEM over a valid/ready handshake. Shifts can optionally run as a 1-bit-per-cycle serial shifter to save area, which makes the stage multi-cycle.

Parameters:
XLEN, 32, operand/result width; power of two.
SERIAL_SHIFT, 1, 1 = SLL/SRL/SRA run serially (one bit per cycle); 0 = all ops single-cycle.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous kill of in-flight and held operation
in_valid  input  1  operation presented
in_ready  output  1  stage can accept this cycle
in_a  input  XLEN  operand A (rs1 / PC)
in_b  input  XLEN  operand B (rs2 / immediate)
in_alu_ctrl  input  4  ALU control code
in_rd  input  5  destination register tag
out_valid  output  1  result register holds a valid result
out_ready  input  1  downstream consumes result
out_result  output  XLEN  registered result
out_zero  output  1  registered (out_result == 0)
out_rd  output  5  registered tag
busy  output  1  serial shift in progress

Behaviour:
- Codes:
  - 0010 ADD; 0110 SUB; 0000 AND; 0001 OR; 0011 XOR.
  - 1000 SLT (signed); 1010 SLTU (unsigned). Both produce a zero-extended 0/1.
  - 1001 SLL; 0101 SRL; 0111 SRA.
  - Any other code: result 0, latency 1.
- Arithmetic is modulo 2^XLEN; no overflow flag.
- Shift amount k = in_b[log2(XLEN)-1:0]; upper bits of in_b are ignored.
- States: IDLE, SHIFT. busy = (state == SHIFT).
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready at a rising edge (cycle T).
- Single-cycle path (non-shift op, SERIAL_SHIFT = 0, or k = 0):
  - Output register loads at the accept edge.
  - out_valid is high from cycle T+1.
- Serial path (SERIAL_SHIFT = 1, shift op, k > 0):
  - At the accept edge, load work = in_a, cnt = k, latch op and rd, go to SHIFT.
  - Each SHIFT cycle: work shifts by 1 (SLL left with 0 fill; SRL right with 0 fill; SRA right with sign fill) and cnt decrements.
  - In the cycle with cnt == 1, the shifted value is written to the output register, out_valid is set and state returns to IDLE.
  - out_valid is high from cycle T+1+k.
  - No accept while in SHIFT. The output register is guaranteed empty during SHIFT.
- Output register:
  - out_valid clears on an out_ready handshake unless a new result loads the same edge; a simultaneous drain and load is allowed back-to-back.
  - out_result, out_zero and out_rd stay stable while out_valid && !out_ready.
- flush:
  - Next edge: out_valid = 0, state = IDLE, in-flight shift discarded.
  - Flush has priority over accept and over shift completion.
  - in_ready is low in the flush cycle; an accept is possible in the following cycle.
- Reset (async assert, sync-to-clk release):
  - out_valid = 0, out_result = 0, out_zero = 0, out_rd = 0, state = IDLE, busy = 0, cnt = 0.
  - Reset mid-shift abandons the operation; nothing is emitted after release.
- Data values are not checked when out_valid = 0, except that they must be stable while held.

Test Plan:
- ADD a=5,b=7,rd=3 -> out_valid in T+1, out_result=12, out_zero=0, out_rd=3. Then SUB 7,7 -> out_result=0, out_zero=1.
- SLT a=0xFFFFFFFF,b=1 -> 1. SLTU same operands -> 0. XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0. Undefined code 1111 -> 0 in T+1.
- SERIAL_SHIFT=1, checking busy and in_ready=0 during each shift:
  - SRA 0x80000000 by 4 -> 0xF8000000, out_valid in T+5.
  - SRL 0x80000000 by 31 -> 0x00000001 in T+32.
  - SLL by 0 -> result = a in T+1.
- Back-pressure: out_ready=0 with two ADDs offered back-to-back.
  - First result held stable, in_ready=0.
  - Raise out_ready -> first result drains and second is accepted the same edge.
  - Second result appears the next cycle.
- flush at T+3 during SLL by 20 -> out_valid never rises for that op, busy drops next cycle, new ADD accepted the cycle after flush. flush while a result is held -> out_valid=0 next cycle.
- Assert rst asynchronously mid-shift (k=20) -> all outputs zero immediately. After release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a registered valid/ready result port and an optional
// bit-serial shifter that makes shifts take one cycle per bit of shift amount.
//
// state | meaning
// IDLE  | ready for a new operation (output register permitting)
// SHIFT | serial shift in progress, one bit per cycle
module ex_alu_stage #(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state, state_nx;
  logic [SHW-1:0]      shamt;
  logic [SHW-1:0]      cnt;
  logic [XLEN-1:0]     work;
  logic [XLEN-1:0]     shift_next;
  logic [XLEN-1:0]     alu_res;
  logic [3:0]          op_q;
  logic [4:0]          rd_q;
  logic                is_shift;
  logic                go_serial;
  logic                accept;
  logic                shift_done;

  assign shamt      = in_b[SHW-1:0];
  assign is_shift   = (in_alu_ctrl == OP_SLL) || (in_alu_ctrl == OP_SRL) ||
                      (in_alu_ctrl == OP_SRA);
  assign go_serial  = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);
  assign accept     = in_valid && in_ready;
  assign shift_done = (state == SHIFT) && (cnt == SHW'(1));

  always_comb begin
    alu_res = '0;
    case (in_alu_ctrl)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    shift_next = work;
    case (op_q)
      OP_SLL:  shift_next = {work[XLEN-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[XLEN-1:1]};
      OP_SRA:  shift_next = {work[XLEN-1], work[XLEN-1:1]};
      default: shift_next = work;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && go_serial) state_nx = SHIFT;
      SHIFT:   if (flush || shift_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == SHIFT);
    in_ready = (state == IDLE) && !flush && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      op_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && go_serial) begin
      work <= in_a;
      cnt  <= shamt;
      op_q <= in_alu_ctrl;
      rd_q <= in_rd;
    end else if (state == SHIFT) begin
      work <= shift_next;
      cnt  <= cnt - SHW'(1);
    end
  end

  // A serial completion never collides with an accept: no accept happens in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_rd     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !go_serial) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_zero   <= (alu_res == '0);
      out_rd     <= in_rd;
    end else if (shift_done) begin
      out_valid  <= 1'b1;
      out_result <= shift_next;
      out_zero   <= (shift_next == '0);
      out_rd     <= rd_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: a latency-level model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_alu_ctrl;
  logic [4:0]  in_rd, out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(32), .SERIAL_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks the result register and the cycles left on a serial shift.
  bit          m_valid;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  int          m_rem;
  logic [31:0] m_pres;
  logic [4:0]  m_prd;
  bit          m_acc;

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: return (a < b) ? 32'd1 : 32'd0;
      4'b1001: return a << k;
      4'b0101: return a >> k;
      4'b0111: return $unsigned($signed(a) >>> k);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_ready();
    return (m_rem == 0) && !flush && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_rem   = 0;
    end else begin
      m_acc = in_valid && m_ready();
      if (flush) begin
        m_valid = 1'b0;
        m_rem   = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_valid  = 1'b1;
          m_result = m_pres;
          m_rd     = m_prd;
        end
      end else begin
        if (out_ready) m_valid = 1'b0;
        if (m_acc) begin
          if ((in_alu_ctrl == 4'b1001 || in_alu_ctrl == 4'b0101 || in_alu_ctrl == 4'b0111)
              && in_b[4:0] != 5'd0) begin
            m_rem  = int'(in_b[4:0]);
            m_pres = model_alu(in_alu_ctrl, in_a, in_b);
            m_prd  = in_rd;
          end else begin
            m_valid  = 1'b1;
            m_result = model_alu(in_alu_ctrl, in_a, in_b);
            m_rd     = in_rd;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_in_ready", 32'(in_ready), 32'(m_ready()));
      check("m_busy", 32'(busy), 32'(m_rem != 0));
      check("m_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("m_out_result", out_result, m_result);
        check("m_out_zero", 32'(out_zero), 32'(m_result == 32'd0));
        check("m_out_rd", 32'(out_rd), 32'(m_rd));
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int tries);
    bit rdy;
    in_alu_ctrl = c; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    tries = 0; rdy = 1'b0;
    while (!rdy && tries < 64) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    if (!rdy) check("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_alu(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
    int t, lat;
    issue(c, a, b, rd, t);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat > 1) begin
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
      end
      if (out_valid) break;
    end
    if (!out_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, out_result, exp);
    check({name, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
    check({name, "_rd"}, 32'(out_rd), 32'(rd));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_alu_ctrl = '0; in_rd = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_alu("add",  4'b0010, 32'd5, 32'd7, 5'd3, 32'd12, 1);
    run_alu("sub",  4'b0110, 32'd7, 32'd7, 5'd4, 32'd0, 1);
    run_alu("slt",  4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1, 1);
    run_alu("sltu", 4'b1010, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 1);
    run_alu("xor",  4'b0011, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd7, 32'h0F0F_F0F0, 1);
    run_alu("undef", 4'b1111, 32'h1234_5678, 32'h1, 5'd8, 32'd0, 1);
    run_alu("sra4", 4'b0111, 32'h8000_0000, 32'd4, 5'd9, 32'hF800_0000, 5);
    run_alu("srl31", 4'b0101, 32'h8000_0000, 32'd31, 5'd10, 32'h0000_0001, 32);
    run_alu("sll0", 4'b1001, 32'hDEAD_BEEF, 32'd32, 5'd11, 32'hDEAD_BEEF, 1);
    run_alu("sll3", 4'b1001, 32'h0000_0013, 32'd3, 5'd12, 32'h0000_0098, 4);

    // back-pressure: second ADD waits until the first result drains
    out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd2, 5'd4, t);
    in_alu_ctrl = 4'b0010; in_a = 32'd10; in_b = 32'd20; in_rd = 5'd5; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", out_result, 32'd3);
      check("bp_hold_rd", 32'(out_rd), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_result", out_result, 32'd30);
    check("bp_second_rd", 32'(out_rd), 32'd5);
    @(posedge clk); #1;

    // flush during a 20-bit serial shift
    issue(4'b1001, 32'd1, 32'd20, 5'd6, t);
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    in_alu_ctrl = 4'b0010; in_a = 32'd100; in_b = 32'd1; in_rd = 5'd7; in_valid = 1'b1;
    @(negedge clk);
    check("fl_busy_after", 32'(busy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("fl_add_valid", 32'(out_valid), 32'd1);
    check("fl_add_result", out_result, 32'd101);
    repeat (25) @(negedge clk);
    check("fl_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // flush while a result is held
    out_ready = 1'b0;
    issue(4'b0010, 32'd2, 32'd2, 5'd8, t);
    @(negedge clk);
    check("flh_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flh_cleared", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // asynchronous reset in the middle of a serial shift
    issue(4'b1001, 32'd3, 32'd20, 5'd9, t);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_result", out_result, 32'd0);
    check("arst_out_zero", 32'(out_zero), 32'd0);
    check("arst_out_rd", 32'(out_rd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("arst_no_stale", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
